// File: rtl/six_instr_controller.sv
// Multi-cycle controller for a six-instruction datapath (NOOP/LOAD/STORE/ADD/SUB/HALT).
// It owns the PC and the IR. All outputs are Moore decodes of the registered state and IR.
module six_instr_controller (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [15:0] I_data,
  output logic [6:0]  PC_addr,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s,
  output logic [3:0]  State_out
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_pc;
  logic [15:0] r_ir;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_INIT;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT) begin
        r_pc <= '0;
      end else if (r_state == S_FETCH) begin
        r_ir <= I_data;
        r_pc <= r_pc + 7'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (r_ir[15:12])
          4'd1:    w_next = S_LOADA;
          4'd2:    w_next = S_STORE;
          4'd3:    w_next = S_ADD;
          4'd4:    w_next = S_SUB;
          4'd5:    w_next = S_HALT;
          default: w_next = S_NOOP;
        endcase
      end
      S_LOADA:  w_next = S_LOADB;
      S_LOADB,
      S_STORE,
      S_ADD,
      S_SUB,
      S_NOOP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_INIT;
    endcase
  end

  always_comb begin
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = 3'd2;
    case (r_state)
      // The write enable waits for LoadB because the RAM read data arrives a cycle late.
      S_LOADA, S_LOADB: begin
        D_addr    = r_ir[7:0];
        RF_s      = 1'b1;
        RF_W_addr = r_ir[11:8];
        RF_W_en   = (r_state == S_LOADB);
      end
      S_STORE: begin
        D_addr     = r_ir[11:4];
        RF_Ra_addr = r_ir[3:0];
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = r_ir[7:4];
        RF_Rb_addr = r_ir[3:0];
        RF_W_addr  = r_ir[11:8];
        RF_W_en    = 1'b1;
        ALU_s      = (r_state == S_SUB) ? 3'd1 : 3'd0;
      end
      default: ;
    endcase
  end

  assign PC_addr   = r_pc;
  assign State_out = r_state;

endmodule

// File: doc/six_instr_controller.md
SIX_INSTR_CONTROLLER -- requirements
Module: six_instr_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named Clk and ResetN as elsewhere in the codebase; all state updates SHALL occur on the rising edge of Clk.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- Clk  in  1  system clock
- ResetN  in  1  asynchronous active-low reset
- I_data  in  16  instruction word from the instruction ROM at PC_addr
- PC_addr  out  7  instruction ROM address, the program counter
- D_addr  out  8  data RAM address
- D_wr  out  1  data RAM write strobe
- RF_s  out  1  register-file write-data select: 1 = RAM read data, 0 = ALU Q
- RF_W_addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_Ra_addr  out  4  register-file read port A address
- RF_Rb_addr  out  4  register-file read port B address
- ALU_s  out  3  ALU function select (0 = add, 1 = sub, 2 = pass A)
- State_out  out  4  current state encoding, for debug display

Function
REQ-003 IR[15:12] SHALL be decoded as the opcode: 0 = NOOP, 1 = LOAD, 2 = STORE, 3 = ADD, 4 = SUB, 5 = HALT; opcodes 6 to 15 SHALL execute as NOOP.
REQ-004 The instruction fields SHALL be:
- LOAD: RF[IR[11:8]] <= RAM[IR[7:0]]
- STORE: RAM[IR[11:4]] <= RF[IR[3:0]]
- ADD/SUB: RF[IR[11:8]] <= RF[IR[7:4]] op RF[IR[3:0]]
REQ-005 The FSM SHALL have the states Init = 0, Fetch = 1, Decode = 2, Noop = 3, LoadA = 4, LoadB = 5, Store = 6, Add = 7, Sub = 8, Halt = 9; State_out SHALL equal the state encoding.
REQ-006 The state transitions SHALL be:
- Init -> Fetch
- Fetch -> Decode
- Decode -> the state for the opcode
- LoadA -> LoadB
- LoadB, Store, Add, Sub, Noop -> Fetch
- Halt -> Halt, exited only by reset
REQ-007 Init SHALL clear the PC to 0 at the clock edge.
REQ-008 In Fetch, IR SHALL load I_data and PC SHALL increment by 1 at the same clock edge; the PC SHALL wrap from 127 to 0.
REQ-009 IR and PC SHALL hold their values in every state other than Fetch (PC is also cleared in Init).
REQ-010 All outputs SHALL be Moore decodes of the registered state and IR, and SHALL be glitch-free relative to Clk.
REQ-011 In LoadA and LoadB, the outputs SHALL be D_addr = IR[7:0], RF_s = 1 and RF_W_addr = IR[11:8]; RF_W_en SHALL be 1 in LoadB only, to cover the synchronous RAM read latency.
REQ-012 In Store, the outputs SHALL be D_addr = IR[11:4], RF_Ra_addr = IR[3:0] and D_wr = 1.
REQ-013 In Add and Sub, the outputs SHALL be RF_Ra_addr = IR[7:4], RF_Rb_addr = IR[3:0], RF_W_addr = IR[11:8], RF_s = 0 and RF_W_en = 1; ALU_s SHALL be 0 in Add and 1 in Sub.
REQ-014 In all other states, D_wr and RF_W_en SHALL be 0, ALU_s SHALL be 2, and the address outputs SHALL be 0.
REQ-015 D_wr and RF_W_en SHALL never both be 1 in the same cycle.
REQ-016 Instruction latency SHALL be 4 cycles for LOAD and 3 cycles for NOOP, STORE, ADD and SUB, each counted from Fetch entry to the next Fetch entry.
REQ-017 Once in Halt, the PC SHALL freeze, no strobes SHALL be asserted, and I_data SHALL be ignored.

Reset
REQ-018 When ResetN = 0, the block SHALL immediately, without waiting for Clk, enter Init with PC = 0 and IR = 0, and drive D_wr = 0, RF_W_en = 0 and ALU_s = 2.
REQ-019 A reset asserted mid-instruction, including in LoadA or Store, SHALL abort that instruction with no further write strobe.
REQ-020 After ResetN rises, the first Fetch SHALL occur on the second rising edge.

Verification
REQ-021 The bench SHALL cover at least the following directed scenarios:
- Reset release with ROM[0] = 0x3210 (ADD R2 = R1 + R0): the state sequence is Init, Fetch, Decode, Add; in Add, RF_W_en = 1, RF_W_addr = 2, RF_Ra_addr = 1, RF_Rb_addr = 0, ALU_s = 0; then PC_addr = 1.
- I_data = 0x1A3C (LOAD RA = RAM[0x3C]): D_addr = 0x3C in LoadA and in LoadB; RF_W_en = 1 only in LoadB; RF_s = 1; RF_W_addr = 0xA.
- I_data = 0x2F07 (STORE RAM[0xF0] = R7): in Store, D_wr = 1 for exactly one cycle, D_addr = 0xF0, RF_Ra_addr = 7.
- I_data = 0x4321 (SUB): ALU_s = 1 and RF_W_addr = 3; then opcode 0x7 executes as NOOP with no strobes.
- With PC = 127 and a NOOP fetched: PC_addr = 0 after Fetch.
- HALT (0x5000) fetched, then 20 cycles: State_out = 9 and PC unchanged throughout; ResetN pulsed low mid-cycle: Init is entered asynchronously and PC = 0.
